// File: rtl/mem_arb_defs_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states and access owner IDs.
package mem_arb_defs;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_WAIT   = 2'd2,
      ARB_RESP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_priority_sel.sv
// CPU-priority winner select with a saturating starvation counter that forces a DMA win
// after STARVE_MAX consecutive CPU grants over a pending DMA request.
module arb_priority_sel #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cpu_req,
   input  logic dma_req,
   input  logic idle,
   input  logic accept,
   output logic win_dma
);

   localparam int            SW   = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic [SW-1:0] starve_cnt;

   assign win_dma = dma_req & (~cpu_req | (starve_cnt == SMAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (accept && win_dma) begin
         starve_cnt <= '0;
      end else if (accept && dma_req) begin
         if (starve_cnt != SMAX)
            starve_cnt <= starve_cnt + 1'b1;
      end else if (idle && !dma_req) begin
         starve_cnt <= '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the multicycle CPU and a DMA master,
// one access in flight at a time, with per-requester req/gnt/done handshakes.
module mem_port_arbiter
   import mem_arb_defs::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int             WCW       = $clog2(MEM_LAT + 1);
   localparam logic [WCW-1:0] WAIT_INIT = WCW'(MEM_LAT - 1);

   arb_state_t     state, state_nxt;
   owner_t         owner;
   logic [WCW-1:0] wait_cnt;
   logic           idle, accept, win_dma;

   assign idle   = (state == ARB_IDLE);
   assign accept = idle & (cpu_req | dma_req);

   arb_priority_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
      .clk     (clk),
      .rst_n   (rst_n),
      .cpu_req (cpu_req),
      .dma_req (dma_req),
      .idle    (idle),
      .accept  (accept),
      .win_dma (win_dma)
   );

   // Grants are combinational so the requester sees acceptance in the same IDLE cycle.
   assign cpu_gnt = idle & cpu_req & ~win_dma;
   assign dma_gnt = idle & win_dma;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ARB_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      busy      = 1'b1;
      cpu_done  = 1'b0;
      dma_done  = 1'b0;
      case (state)
         ARB_IDLE: begin
            busy = 1'b0;
            if (cpu_req || dma_req)
               state_nxt = ARB_ACCESS;
         end
         ARB_ACCESS: begin
            mem_en    = 1'b1;
            state_nxt = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (wait_cnt == '0)
               state_nxt = ARB_RESP;
         end
         ARB_RESP: begin
            cpu_done  = (owner == OWN_CPU);
            dma_done  = (owner == OWN_DMA);
            state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Command latch, wait counter and read-data capture; the latch drives the memory pins directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= OWN_CPU;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wait_cnt  <= '0;
         rdata     <= '0;
      end else begin
         if (accept) begin
            owner     <= win_dma ? OWN_DMA : OWN_CPU;
            mem_we    <= win_dma ? dma_we : cpu_we;
            mem_addr  <= win_dma ? dma_addr : cpu_addr;
            mem_wdata <= win_dma ? dma_wdata : cpu_wdata;
         end
         if (state == ARB_ACCESS)
            wait_cnt <= WAIT_INIT;
         else if (state == ARB_WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - 1'b1;
         if (state == ARB_WAIT && wait_cnt == '0 && !mem_we)
            rdata <= mem_rdata;
      end
   end

endmodule
